// File: rtl/adxl362_fifo.sv
// ADXL362-style sample FIFO: packs x/y/z (and optionally temperature) into tagged 16-bit words.
// Optional temperature word is enabled by defining ADXL362_FIFO_TEMP_EN.
module adxl362_fifo #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk_16mhz,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [11:0]   xdata,
    input  logic [11:0]   ydata,
    input  logic [11:0]   zdata,
    input  logic [11:0]   temperature,
    input  logic [3:0]    fifo_ctrl,
    input  logic [7:0]    fifo_samples,
    input  logic          read_req,
    output logic [15:0]   read_data,
    output logic [AW:0]   fifo_entries,
    output logic          fifo_ready,
    output logic          fifo_watermark,
    output logic          fifo_overrun,
    output logic [2:0]    fsm_state
);
    // Handshake: sample_valid and read_req are single-cycle strobes with no back-pressure;
    // a sample set is accepted only in IDLE, a pop only when fifo_entries != 0.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR_X = 3'd1,
        WR_Y = 3'd2,
        WR_Z = 3'd3
`ifdef ADXL362_FIFO_TEMP_EN
        , WR_T = 3'd4
`endif
    } state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [11:0]   x_hold, y_hold, z_hold;
    logic [15:0]   wr_word;
    logic [AW:0]   next_entries, free;
    logic [2:0]    set_size;
    logic [8:0]    wm_thr;
    logic          disabled, stream, wr_en, pop, full, overwrite, accept, drop;

`ifdef ADXL362_FIFO_TEMP_EN
    logic [11:0]   t_hold;
    logic          t_en_hold;
    assign set_size = fifo_ctrl[2] ? 3'd4 : 3'd3;
`else
    logic unused_temp_inputs;
    assign unused_temp_inputs = ^{temperature, fifo_ctrl[2]};
    assign set_size = 3'd3;
`endif

    assign disabled  = (fifo_ctrl[1:0] == 2'b00);
    assign stream    = fifo_ctrl[1];
    assign wm_thr    = {fifo_ctrl[3], fifo_samples};
    assign free      = (AW+1)'(DEPTH) - fifo_entries;
    assign full      = (fifo_entries == (AW+1)'(DEPTH));
    assign wr_en     = (state != IDLE) && !disabled;
    assign pop       = read_req && (fifo_entries != '0) && !disabled;
    // A simultaneous pop makes room, so the oldest word is only discarded without one.
    assign overwrite = wr_en && !pop && full;
    assign accept    = sample_valid && (state == IDLE) && (stream || 32'(free) >= 32'(set_size));
    assign drop      = sample_valid && !accept;
    assign fsm_state = state;

    always_comb begin
        wr_word = '0;
        case (state)
            WR_X: wr_word = {2'b00, {2{x_hold[11]}}, x_hold};
            WR_Y: wr_word = {2'b01, {2{y_hold[11]}}, y_hold};
            WR_Z: wr_word = {2'b10, {2{z_hold[11]}}, z_hold};
`ifdef ADXL362_FIFO_TEMP_EN
            WR_T: wr_word = {2'b11, {2{t_hold[11]}}, t_hold};
`endif
            default: ;
        endcase
    end

    always_comb begin
        next_entries = fifo_entries;
        if (wr_en && !pop && !full)
            next_entries = fifo_entries + (AW+1)'(1);
        else if (pop && !wr_en)
            next_entries = fifo_entries - (AW+1)'(1);
    end

    always_ff @(posedge clk_16mhz) begin
        if (wr_en)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk_16mhz or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_entries   <= '0;
            read_data      <= '0;
            fifo_ready     <= 1'b0;
            fifo_watermark <= 1'b0;
            fifo_overrun   <= 1'b0;
            x_hold         <= '0;
            y_hold         <= '0;
            z_hold         <= '0;
`ifdef ADXL362_FIFO_TEMP_EN
            t_hold         <= '0;
            t_en_hold      <= 1'b0;
`endif
        end else if (disabled) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_entries   <= '0;
            fifo_ready     <= 1'b0;
            fifo_watermark <= 1'b0;
            fifo_overrun   <= 1'b0;
            if (read_req)
                read_data <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    x_hold <= xdata;
                    y_hold <= ydata;
                    z_hold <= zdata;
`ifdef ADXL362_FIFO_TEMP_EN
                    t_hold    <= temperature;
                    t_en_hold <= fifo_ctrl[2];
`endif
                    state  <= WR_X;
                end
                WR_X: state <= WR_Y;
                WR_Y: state <= WR_Z;
`ifdef ADXL362_FIFO_TEMP_EN
                WR_Z: state <= t_en_hold ? WR_T : IDLE;
                WR_T: state <= IDLE;
`else
                WR_Z: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase

            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop || overwrite)
                rd_ptr <= rd_ptr + AW'(1);
            if (pop)
                read_data <= mem[rd_ptr];
            else if (read_req)
                read_data <= '0;

            fifo_entries   <= next_entries;
            fifo_ready     <= (next_entries != '0);
            fifo_watermark <= (wm_thr != '0) && (32'(next_entries) >= 32'(wm_thr));

            if (overwrite || drop)
                fifo_overrun <= 1'b1;
            else if (pop && !wr_en && fifo_entries == (AW+1)'(1))
                fifo_overrun <= 1'b0;
        end
    end
endmodule
